// File: rtl/instr_seq_ctrl_if.sv
// Bus bundle between the instruction sequencer and its surroundings:
// instruction memory, decoder/register file and ALU flag outputs.
interface instr_seq_ctrl_if;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        dec_we;
    logic        rf_we;
    logic        alu_zr;
    logic        alu_neg;
    logic        alu_ov;
    logic        ext_stall;
    logic        N;
    logic        Z;
    logic        V;
    logic        halted;
    logic        timeout_err;
    logic [31:0] instr_cnt;
    logic [31:0] cycle_cnt;

    modport master (
        output imem_rd, imem_addr, instr, pc, rf_we, N, Z, V, halted, timeout_err,
               instr_cnt, cycle_cnt,
        input  imem_rdy, imem_data, dec_we, alu_zr, alu_neg, alu_ov, ext_stall
    );

    modport slave (
        input  imem_rd, imem_addr, instr, pc, rf_we, N, Z, V, halted, timeout_err,
               instr_cnt, cycle_cnt,
        output imem_rdy, imem_data, dec_we, alu_zr, alu_neg, alu_ov, ext_stall
    );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer owning PC, IR, N/Z/V flags and RF write gating.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module instr_seq_ctrl #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    instr_seq_ctrl_if.master bus
);
    localparam logic [7:0] TMO = 8'(IMEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        n_q, n_d, z_q, z_d, v_q, v_d;
    logic        halted_q, halted_d;
    logic        terr_q, terr_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        taken;
    logic [3:0]  op;

    assign op = ir_q[15:12];

    // Branch condition uses the flags as they stand before this EXEC.
    always_comb begin
        taken = 1'b0;
        case (ir_q[11:9])
            3'b000:  taken = ~z_q;
            3'b001:  taken = z_q;
            3'b010:  taken = ~z_q & ~n_q;
            3'b011:  taken = n_q;
            3'b100:  taken = ~n_q;
            3'b101:  taken = n_q | z_q;
            3'b110:  taken = v_q;
            default: taken = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            halted_q <= 1'b0;
            terr_q   <= 1'b0;
            tcnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            n_q      <= n_d;
            z_q      <= z_d;
            v_q      <= v_d;
            halted_q <= halted_d;
            terr_q   <= terr_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        n_d      = n_q;
        z_d      = z_q;
        v_d      = v_q;
        halted_d = halted_q;
        terr_d   = terr_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (bus.imem_rdy) begin
                    ir_d    = bus.imem_data;
                    tcnt_d  = 8'd0;
                    state_d = EXEC;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (tcnt_d == TMO) begin
                        terr_d   = 1'b1;
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                end
            end
            EXEC: begin
                if (!bus.ext_stall) begin
                    if (op == 4'hF) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        if (op == 4'hC && taken)
                            pc_d = pc_q + 16'd1 + {{7{ir_q[8]}}, ir_q[8:0]};
                        else
                            pc_d = pc_q + 16'd1;
                        if (op <= 4'h7) z_d = bus.alu_zr;
                        if (op <= 4'h2) begin
                            n_d = bus.alu_neg;
                            v_d = bus.alu_ov;
                        end
                        state_d = FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.imem_rd     = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = ir_q;
    assign bus.pc          = pc_q;
    assign bus.rf_we       = (state_q == EXEC) & bus.dec_we & ~bus.ext_stall;
    assign bus.N           = n_q;
    assign bus.Z           = z_q;
    assign bus.V           = v_q;
    assign bus.halted      = halted_q;
    assign bus.timeout_err = terr_q;

`ifdef PERF_CNT_EN
    logic [31:0] icnt_q, ccnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            icnt_q <= 32'd0;
            ccnt_q <= 32'd0;
        end else begin
            if (state_q != HALT) ccnt_q <= ccnt_q + 32'd1;
            if (state_q == EXEC && !bus.ext_stall) icnt_q <= icnt_q + 32'd1;
        end
    end

    assign bus.instr_cnt = icnt_q;
    assign bus.cycle_cnt = ccnt_q;
`else
    assign bus.instr_cnt = 32'd0;
    assign bus.cycle_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl with a 32-word aliasing instruction memory.
module tb_instr_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy_en = 1'b1;
    logic [15:0] mem [0:31];
    int n_chk = 0;
    int n_pass = 0;

    instr_seq_ctrl_if bus ();

    instr_seq_ctrl #(.IMEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr[4:0]];
    assign bus.imem_rdy  = rdy_en;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fill(16'h0123);
        rdy_en = 1'b1; bus.dec_we = 1'b1; bus.ext_stall = 1'b0;
        bus.alu_zr = 1'b0; bus.alu_neg = 1'b0; bus.alu_ov = 1'b0;
        do_reset();
        n_chk++; if (bus.imem_rd !== 1'b0) $display("FAIL rst_rd: got %b exp 0", bus.imem_rd); else n_pass++;
        n_chk++; if (bus.pc !== 16'h0000) $display("FAIL rst_pc: got %h exp 0000", bus.pc); else n_pass++;
        n_chk++; if (bus.instr !== 16'h0000) $display("FAIL rst_ir: got %h exp 0000", bus.instr); else n_pass++;
        n_chk++; if ({bus.N, bus.Z, bus.V} !== 3'b000) $display("FAIL rst_flags: got %b exp 000", {bus.N, bus.Z, bus.V}); else n_pass++;
        n_chk++; if ({bus.halted, bus.timeout_err} !== 2'b00) $display("FAIL rst_halt: got %b exp 00", {bus.halted, bus.timeout_err}); else n_pass++;
        n_chk++; if (bus.rf_we !== 1'b0) $display("FAIL rst_rfwe: got %b exp 0", bus.rf_we); else n_pass++;
    endtask

    task automatic test_sequence();
        fill(16'h0123);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if ({bus.imem_rd, bus.rf_we} !== 2'b10) $display("FAIL seq_fetch%0d: got rd/we %b exp 10", i, {bus.imem_rd, bus.rf_we}); else n_pass++;
            n_chk++; if (bus.imem_addr !== 16'(i)) $display("FAIL seq_addr%0d: got %h exp %h", i, bus.imem_addr, 16'(i)); else n_pass++;
            tick();
            n_chk++; if ({bus.imem_rd, bus.rf_we} !== 2'b01) $display("FAIL seq_exec%0d: got rd/we %b exp 01", i, {bus.imem_rd, bus.rf_we}); else n_pass++;
            n_chk++; if (bus.instr !== 16'h0123) $display("FAIL seq_ir%0d: got %h exp 0123", i, bus.instr); else n_pass++;
        end
    endtask

    task automatic test_branch(input logic zr, input logic [15:0] exp_addr);
        fill(16'h0123);
        mem[1] = 16'hC202;
        do_reset();
        bus.alu_zr = zr;
        tick(); tick(); tick();
        n_chk++; if (bus.Z !== zr) $display("FAIL br_z%0b: got %b exp %b", zr, bus.Z, zr); else n_pass++;
        bus.alu_zr = ~zr;
        tick(); tick();
        n_chk++; if (bus.imem_addr !== exp_addr) $display("FAIL br_addr_z%0b: got %h exp %h", zr, bus.imem_addr, exp_addr); else n_pass++;
        n_chk++; if (bus.Z !== zr) $display("FAIL br_zkeep%0b: got %b exp %b", zr, bus.Z, zr); else n_pass++;
        bus.alu_zr = 1'b0;
    endtask

    task automatic test_branch_wrap();
        fill(16'h0123);
        mem[0] = 16'hCFFF;
        do_reset();
        tick(); tick(); tick();
        n_chk++; if (bus.imem_addr !== 16'h0000) $display("FAIL wrap_neg: got %h exp 0000", bus.imem_addr); else n_pass++;
        mem[0] = 16'hCFFD;
        mem[30] = 16'hCE01;
        do_reset();
        tick(); tick(); tick();
        n_chk++; if (bus.imem_addr !== 16'hFFFE) $display("FAIL wrap_back: got %h exp fffe", bus.imem_addr); else n_pass++;
        tick(); tick();
        n_chk++; if (bus.imem_addr !== 16'h0000) $display("FAIL wrap_fwd: got %h exp 0000", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_flags();
        fill(16'h0123);
        mem[1] = 16'h3000; mem[2] = 16'h8000; mem[3] = 16'hC603;
        do_reset();
        {bus.alu_neg, bus.alu_ov, bus.alu_zr} = 3'b110;
        tick(); tick(); tick();
        n_chk++; if ({bus.N, bus.Z, bus.V} !== 3'b101) $display("FAIL flg_add: got %b exp 101", {bus.N, bus.Z, bus.V}); else n_pass++;
        {bus.alu_neg, bus.alu_ov, bus.alu_zr} = 3'b001;
        tick(); tick();
        n_chk++; if ({bus.N, bus.Z, bus.V} !== 3'b111) $display("FAIL flg_op3: got %b exp 111", {bus.N, bus.Z, bus.V}); else n_pass++;
        {bus.alu_neg, bus.alu_ov, bus.alu_zr} = 3'b000;
        tick(); tick();
        n_chk++; if ({bus.N, bus.Z, bus.V} !== 3'b111) $display("FAIL flg_op8: got %b exp 111", {bus.N, bus.Z, bus.V}); else n_pass++;
        tick(); tick();
        n_chk++; if (bus.imem_addr !== 16'h0007) $display("FAIL flg_brn: got %h exp 0007", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_timeout();
        fill(16'h0123);
        do_reset();
        rdy_en = 1'b0;
        tick(); tick(); tick(); tick();
        n_chk++; if ({bus.imem_rd, bus.halted} !== 2'b10) $display("FAIL tmo_pre: got rd/halt %b exp 10", {bus.imem_rd, bus.halted}); else n_pass++;
        tick();
        n_chk++; if ({bus.halted, bus.timeout_err, bus.imem_rd} !== 3'b110) $display("FAIL tmo_hit: got %b exp 110", {bus.halted, bus.timeout_err, bus.imem_rd}); else n_pass++;
        rdy_en = 1'b1;
        tick(); tick();
        n_chk++; if ({bus.halted, bus.imem_rd} !== 2'b10) $display("FAIL tmo_stay: got %b exp 10", {bus.halted, bus.imem_rd}); else n_pass++;
        do_reset();
        n_chk++; if ({bus.halted, bus.timeout_err} !== 2'b00) $display("FAIL tmo_clr: got %b exp 00", {bus.halted, bus.timeout_err}); else n_pass++;
    endtask

    task automatic test_halt();
        fill(16'h0123);
        mem[0] = 16'hCE0F; mem[16] = 16'hF000;
        do_reset();
        tick(); tick(); tick(); tick();
        n_chk++; if (bus.instr !== 16'hF000) $display("FAIL hlt_ir: got %h exp f000", bus.instr); else n_pass++;
        tick();
        n_chk++; if ({bus.halted, bus.imem_rd} !== 2'b10) $display("FAIL hlt_state: got %b exp 10", {bus.halted, bus.imem_rd}); else n_pass++;
        tick(); tick(); tick();
        n_chk++; if (bus.pc !== 16'h0010) $display("FAIL hlt_pc: got %h exp 0010", bus.pc); else n_pass++;
        n_chk++; if ({bus.halted, bus.imem_rd, bus.rf_we} !== 3'b100) $display("FAIL hlt_hold: got %b exp 100", {bus.halted, bus.imem_rd, bus.rf_we}); else n_pass++;
    endtask

    task automatic test_stall();
        fill(16'h0123);
        do_reset();
        tick();
        bus.ext_stall = 1'b1; bus.alu_zr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if ({bus.rf_we, bus.Z, bus.imem_rd} !== 3'b000) $display("FAIL stl_cyc%0d: got we/z/rd %b exp 000", i, {bus.rf_we, bus.Z, bus.imem_rd}); else n_pass++;
            n_chk++; if (bus.pc !== 16'h0000) $display("FAIL stl_pc%0d: got %h exp 0000", i, bus.pc); else n_pass++;
        end
        bus.ext_stall = 1'b0;
        #1;
        n_chk++; if (bus.rf_we !== 1'b1) $display("FAIL stl_rel: got %b exp 1", bus.rf_we); else n_pass++;
        tick();
        n_chk++; if ({bus.imem_addr, bus.Z} !== {16'h0001, 1'b1}) $display("FAIL stl_after: got %h/%b exp 0001/1", bus.imem_addr, bus.Z); else n_pass++;
        bus.alu_zr = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill(16'h0123);
        do_reset();
        rdy_en = 1'b0;
        tick(); tick();
        do_reset();
        n_chk++; if ({bus.imem_rd, bus.timeout_err} !== 2'b00) $display("FAIL rmid_fetch: got %b exp 00", {bus.imem_rd, bus.timeout_err}); else n_pass++;
        rdy_en = 1'b1;
        bus.alu_zr = 1'b1;
        tick(); tick(); tick(); tick();
        n_chk++; if ({bus.pc, bus.Z} !== {16'h0001, 1'b1}) $display("FAIL rmid_pre: got %h/%b exp 0001/1", bus.pc, bus.Z); else n_pass++;
        do_reset();
        n_chk++; if ({bus.pc, bus.instr, bus.Z} !== {16'h0000, 16'h0000, 1'b0}) $display("FAIL rmid_exec: got %h/%h/%b exp 0000/0000/0", bus.pc, bus.instr, bus.Z); else n_pass++;
        bus.alu_zr = 1'b0;
    endtask

    task automatic test_perf();
        fill(16'h0123);
        mem[4] = 16'hF000;
        do_reset();
        for (int i = 0; i < 11; i++) tick();
        n_chk++; if (bus.halted !== 1'b1) $display("FAIL perf_halt: got %b exp 1", bus.halted); else n_pass++;
`ifdef PERF_CNT_EN
        n_chk++; if (bus.instr_cnt !== 32'd5) $display("FAIL perf_icnt: got %0d exp 5", bus.instr_cnt); else n_pass++;
        n_chk++; if (bus.cycle_cnt !== 32'd11) $display("FAIL perf_ccnt: got %0d exp 11", bus.cycle_cnt); else n_pass++;
        tick(); tick(); tick();
        n_chk++; if (bus.cycle_cnt !== 32'd11) $display("FAIL perf_frz: got %0d exp 11", bus.cycle_cnt); else n_pass++;
`else
        n_chk++; if ({bus.instr_cnt, bus.cycle_cnt} !== 64'd0) $display("FAIL perf_off: got %h exp 0", {bus.instr_cnt, bus.cycle_cnt}); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_branch(1'b1, 16'h0004);
        test_branch(1'b0, 16'h0002);
        test_branch_wrap();
        test_flags();
        test_timeout();
        test_halt();
        test_stall();
        test_reset_mid();
        test_perf();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
